// File: rtl/multi_score_counter_pkg.sv
// Shared constants, types and the bounded-step helper for the score counters.
// No ports; imported by the channel, top and interface users.
package scoreboard_pkg;

    localparam int SCORE_BW  = 7;
    localparam int SCORE_MAX = 99;

    // Bound handling mode, driven directly from wrap_en_i
    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Per-channel action after priority resolution
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DOWN = 2'd3
    } act_e;

    typedef struct packed {
        logic [31:0] nxt;
        logic        evt;
    } bound_res_t;

    // Next bounded value. Arithmetic is carried at 32 bits, which is wider
    // than any legal BW+1, so val+s never overflows before the bound test.
    function automatic bound_res_t bound_step(
        input logic [31:0] val,
        input logic [31:0] s,
        input logic        dir,
        input logic        mode,
        input logic [31:0] max_v
    );
        bound_res_t  r;
        logic [31:0] sum;
        r.nxt = val;
        r.evt = 1'b0;
        sum   = val + s;
        if (dir == DIR_UP) begin
            if (sum <= max_v) begin
                r.nxt = sum;
            end else begin
                r.evt = 1'b1;
                r.nxt = (mode == MODE_WRAP) ? sum - (max_v + 32'd1) : max_v;
            end
        end else begin
            if (val >= s) begin
                r.nxt = val - s;
            end else begin
                r.evt = 1'b1;
                r.nxt = (mode == MODE_WRAP) ? val + (max_v + 32'd1) - s
                                            : 32'd0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_score_counter_if.sv
// Request/status bundle between the button front end and the counter bank.
// master: drives up/down/clr/wrap/step, reads values and flags; slave: the bank.
interface multi_score_counter_if #(
    parameter int NUM_CH = 2,
    parameter int BW     = 7,
    parameter int STEP_W = 1
);
    logic [NUM_CH-1:0]    up_i;
    logic [NUM_CH-1:0]    down_i;
    logic [NUM_CH-1:0]    clr_i;
    logic                 wrap_en_i;
    logic [STEP_W-1:0]    step_i;
    logic [NUM_CH*BW-1:0] counter_val_o;
    logic [NUM_CH-1:0]    at_max_o;
    logic [NUM_CH-1:0]    at_min_o;
    logic [NUM_CH-1:0]    limit_evt_o;

    modport master (
        output up_i, down_i, clr_i, wrap_en_i, step_i,
        input  counter_val_o, at_max_o, at_min_o, limit_evt_o
    );

    modport slave (
        input  up_i, down_i, clr_i, wrap_en_i, step_i,
        output counter_val_o, at_max_o, at_min_o, limit_evt_o
    );
endinterface

// File: rtl/multi_score_counter_score_channel.sv
// One bounded up/down score counter with rising-edge detect and clear.
// Ports: clk_i, rst_i, up_i, down_i, clr_i, wrap_en_i, step_i -> val_o, evt_o.
module score_channel
    import scoreboard_pkg::*;
#(
    parameter int BW      = SCORE_BW,
    parameter int MAX_VAL = SCORE_MAX,
    parameter int STEP_W  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              up_i,
    input  logic              down_i,
    input  logic              clr_i,
    input  logic              wrap_en_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [BW-1:0]     val_o,
    output logic              evt_o
);

    logic [BW-1:0]     val_q, val_d;
    logic              evt_q, evt_d;
    logic              up_q, down_q;
    logic              up_rise, down_rise;
    logic [STEP_W-1:0] s;
    act_e              act;
    logic [31:0]       nxt_w;
    logic              evt_w;

    assign up_rise   = up_i & ~up_q;
    assign down_rise = down_i & ~down_q;

    // Priority: clear, then opposing edges cancel, then single direction
    always_comb begin
        act = ACT_HOLD;
        if (clr_i) begin
            act = ACT_CLR;
        end else if (up_rise && !down_rise) begin
            act = ACT_UP;
        end else if (down_rise && !up_rise) begin
            act = ACT_DOWN;
        end
    end

    always_comb begin
        s = (step_i == '0) ? STEP_W'(1) : step_i;
        {nxt_w, evt_w} = bound_step(
            32'(val_q),
            32'(s),
            (act == ACT_DOWN) ? DIR_DOWN : DIR_UP,
            wrap_en_i ? MODE_WRAP : MODE_SAT,
            32'(MAX_VAL)
        );
    end

    // Result never exceeds MAX_VAL, so the upper bits are always zero
    wire unused_nxt_hi = ^nxt_w[31:BW];

    always_comb begin
        val_d = val_q;
        evt_d = 1'b0;
        unique case (act)
            ACT_HOLD: begin
                val_d = val_q;
            end
            ACT_CLR: begin
                val_d = '0;
            end
            ACT_UP, ACT_DOWN: begin
                val_d = nxt_w[BW-1:0];
                evt_d = evt_w;
            end
            default: begin
                val_d = val_q;
            end
        endcase
    end

    // Edge history updates even during clear so a clear swallows the edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q  <= '0;
            evt_q  <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            evt_q  <= evt_d;
            up_q   <= up_i;
            down_q <= down_i;
        end
    end

    assign val_o = val_q;
    assign evt_o = evt_q;

endmodule

// File: rtl/multi_score_counter.sv
// Bank of NUM_CH independent bounded score counters for the scoreboard.
// Ports: clk_i, rst_i, bus (slave): up/down/clr/wrap/step in; values and flags out.
module multi_score_counter
    import scoreboard_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int BW      = SCORE_BW,
    parameter int MAX_VAL = SCORE_MAX,
    parameter int STEP_W  = 1
) (
    input logic                 clk_i,
    input logic                 rst_i,
    multi_score_counter_if.slave bus
);

    if (MAX_VAL >= (1 << BW)) begin : g_bad_max
        $error("MAX_VAL does not fit in BW bits");
    end

    logic [NUM_CH*BW-1:0] val_pk;
    logic [NUM_CH-1:0]    max_pk;
    logic [NUM_CH-1:0]    min_pk;
    logic [NUM_CH-1:0]    evt_pk;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [BW-1:0] val;
        logic          evt;

        score_channel #(
            .BW      (BW),
            .MAX_VAL (MAX_VAL),
            .STEP_W  (STEP_W)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .up_i      (bus.up_i[k]),
            .down_i    (bus.down_i[k]),
            .clr_i     (bus.clr_i[k]),
            .wrap_en_i (bus.wrap_en_i),
            .step_i    (bus.step_i),
            .val_o     (val),
            .evt_o     (evt)
        );

        assign val_pk[k*BW +: BW] = val;
        assign max_pk[k]          = (val == BW'(MAX_VAL));
        assign min_pk[k]          = (val == '0);
        assign evt_pk[k]          = evt;
    end

    assign bus.counter_val_o = val_pk;
    assign bus.at_max_o      = max_pk;
    assign bus.at_min_o      = min_pk;
    assign bus.limit_evt_o   = evt_pk;

endmodule

// File: doc/multi_score_counter.md
Name: multi_score_counter

Overview:
- Parametrised bank of NUM_CH independent up/down score counters for the scoreboard, one per team/player.
- Replaces dual-edge-clocked counting with a single system clock.
- Button inputs are sampled as synchronous levels; each rising edge is one step.
- Each channel is bounded to [0, MAX_VAL] and runs in saturate or wrap mode. Per-channel values feed the display driver.

Parameters:
- NUM_CH, 2, number of independent counter channels.
- BW, 7, bit width of each counter value.
- MAX_VAL, 99, upper bound of each counter. Must be < 2**BW (elaboration-time check).
- STEP_W, 1, bit width of step_i. Step size is a runtime value of 1..2**STEP_W-1.

Ports:
- clk_i  input  1  system clock; all state updates on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- up_i  input  NUM_CH  per-channel count-up request level; already synchronised and debounced upstream.
- down_i  input  NUM_CH  per-channel count-down request level; same conditioning.
- clr_i  input  NUM_CH  per-channel synchronous clear, level-sensitive.
- wrap_en_i  input  1  0 = saturate at bounds, 1 = wrap around at bounds; global to all channels.
- step_i  input  STEP_W  increment/decrement amount. Value 0 is treated as 1.
- counter_val_o  output  NUM_CH*BW  packed counter values; channel k occupies bits [k*BW +: BW].
- at_max_o  output  NUM_CH  channel value equals MAX_VAL (combinational from register).
- at_min_o  output  NUM_CH  channel value equals 0 (combinational from register).
- limit_evt_o  output  NUM_CH  one-cycle pulse when a step was clipped (saturate) or wrapped (wrap).

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All counters go to 0.
  - Edge-detect history registers go to 0.
  - limit_evt_o goes to 0; at_min_o is all-ones; at_max_o is all-zeros.
  - Reset has priority over every other input and aborts any pending edge.
- Edge detection:
  - Each channel registers up_i/down_i each cycle.
  - up_rise = up_i & ~up_q; down_rise likewise.
  - A level held high produces exactly one step.
  - After reset, an input already high is treated as a new edge on the first non-reset cycle, because history is 0.
- Latency: a rise sampled at edge n updates counter_val_o after edge n; the new value is visible in cycle n+1. limit_evt_o pulses in that same cycle.
- Per-channel priority: rst_i > clr_i > (up_rise & down_rise) > up_rise > down_rise > hold.
- clr_i=1: counter goes to 0, limit_evt_o=0, and edge history still updates. An edge during clear is consumed, not deferred.
- Simultaneous up_rise and down_rise: no change, no event.
- Effective step s = (step_i==0) ? 1 : step_i.
- Up, saturate mode:
  - If val + s <= MAX_VAL, then val += s.
  - Otherwise val = MAX_VAL and limit_evt=1. This includes val already at MAX_VAL.
- Up, wrap mode:
  - If val + s > MAX_VAL, then val = val + s - (MAX_VAL+1) and limit_evt=1.
  - Example with MAX_VAL=99: 98 + 3 gives 1.
- Down, saturate mode:
  - If val >= s, then val -= s.
  - Otherwise val = 0 and limit_evt=1.
- Down, wrap mode:
  - If val < s, then val = val + (MAX_VAL+1) - s and limit_evt=1.
  - Example: 1 - 3 gives 98.
- Width rule: sums are computed at BW+1 bits so there is no intermediate overflow. Results are always within [0, MAX_VAL].
- wrap_en_i and step_i are sampled in the same cycle as the edge. Changing them between edges has no effect on held values.
- Channels are fully independent. Any combination of simultaneous events across channels is processed in the same cycle.

Decomposition:
- Package scoreboard_pkg holds:
  - default constants SCORE_BW=7, SCORE_MAX=99;
  - localparam for priority/mode encoding (MODE_SAT=0, MODE_WRAP=1);
  - the helper function computing the next bounded value (val, s, dir, mode) -> {next, evt}.
- Sub-module score_channel: one counter with edge detection, clear and bound logic. It is instantiated NUM_CH times via generate in multi_score_counter, which only does packing and flag fan-out.

Test Plan:
- Reset then single pulses: rst_i for 2 cycles; then three separate 1-cycle up_i[0] pulses with step_i=1 -> ch0 = 3, ch1 = 0, no limit_evt.
- Held level and simultaneous edges:
  - Hold up_i[1] high for 10 cycles -> ch1 increments exactly once.
  - Raise up_i[0] and down_i[0] together -> ch0 unchanged, no event.
- Saturate bounds (wrap_en_i=0):
  - Drive ch0 to 98, then step_i=3 up -> ch0=99, limit_evt_o[0] one-cycle pulse, at_max_o[0]=1.
  - A further up -> stays 99 and pulses again.
  - From 0, down -> stays 0 and pulses.
- Wrap bounds (wrap_en_i=1):
  - 98 + 3 -> 1 with event pulse.
  - 1 - 3 -> 98 with event.
  - 99 + 1 -> 0 with event.
- Clear and reset priority:
  - clr_i[1] asserted together with up_rise at value 50 -> 0, no event.
  - rst_i asserted mid-sequence with edges on both channels -> all values 0, and no step is applied on the following cycle unless an input is high.
